// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input-conditioning slice.
//   - PS/2 scan codes as 9-bit {extended, code} values
//   - direction bit indices, used by every 4-bit direction vector
//   - coin FSM state type and the decoded key-state record
//   - small helpers: lowest-set-bit isolation and display rotation
package arcade_input_pkg;

  localparam int DIR_UP = 0;
  localparam int DIR_DN = 1;
  localparam int DIR_LF = 2;
  localparam int DIR_RT = 3;

  localparam logic [8:0] KEY_UP       = 9'h175;
  localparam logic [8:0] KEY_DN       = 9'h172;
  localparam logic [8:0] KEY_LF       = 9'h16B;
  localparam logic [8:0] KEY_RT       = 9'h174;
  localparam logic [8:0] KEY_FIRE_A   = 9'h029;
  localparam logic [8:0] KEY_FIRE_B   = 9'h014;
  localparam logic [8:0] KEY_START1_A = 9'h005;
  localparam logic [8:0] KEY_START1_B = 9'h016;
  localparam logic [8:0] KEY_START2_A = 9'h006;
  localparam logic [8:0] KEY_START2_B = 9'h01E;
  localparam logic [8:0] KEY_COIN1    = 9'h02E;
  localparam logic [8:0] KEY_COIN2    = 9'h036;
  localparam logic [8:0] KEY_RACK     = 9'h003;
  localparam logic [8:0] KEY_UP2      = 9'h02D;
  localparam logic [8:0] KEY_DN2      = 9'h02B;
  localparam logic [8:0] KEY_LF2      = 9'h023;
  localparam logic [8:0] KEY_RT2      = 9'h034;

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_REL} coin_state_e;

  // Held-state of every mapped key. dir[p] is indexed by DIR_*.
  typedef struct packed {
    logic [1:0][3:0] dir;
    logic            start1;
    logic            start2;
    logic [1:0]      coin;
    logic            rack;
  } key_state_t;

  // One-hot of the lowest set bit (0 when v is 0).
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Horizontal cabinets: up'=left, dn'=right, lf'=down, rt'=up.
  function automatic logic [3:0] orient(input logic [3:0] d, input logic horz);
    return horz ? {d[DIR_UP], d[DIR_DN], d[DIR_RT], d[DIR_LF]} : d;
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_dir4_arb.sv
// dir4_arb: last-pressed-wins 4-way direction arbiter for one player.
//   clk_sys, reset_n : clock, async active-low reset
//   raw[3:0]         : held directions (DIR_* order)
//   dir[3:0]         : registered one-hot (or zero) winning direction
// A fresh press takes over; when the winner is released the lowest-index
// still-held direction takes its place. One cycle raw->dir.
module dir4_arb
  import arcade_input_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [3:0] raw,
  output logic [3:0] dir
);

  logic [3:0] raw_q;
  logic [3:0] rise;
  logic [3:0] dir_d;

  assign rise = raw & ~raw_q;

  always_comb begin
    dir_d = '0;
    if (|rise)            dir_d = lowest_one(rise);
    else if (|(dir & raw)) dir_d = dir;   // winner still held: keep it
    else                  dir_d = lowest_one(raw);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= '0;
      dir   <= '0;
    end else begin
      raw_q <= raw;
      dir   <= dir_d;
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: conditions keyboard/joystick input for the pacman core.
//   clk_sys, reset_n      : clock, async active-low reset
//   ps2_key[10:0]         : {toggle, pressed, ext, code}
//   joystick_0/1[15:0]    : [0]R [1]L [2]D [3]U [4]start1 [5]start2
//   vblank                : rising edge = frame tick (coin stretching)
//   horz                  : rotate directions for a horizontal display
//   cocktail              : DIP level, reported on in1_n[7]
//   in0_n[7:0]            : ~{0, coin2, coin1, rack, dn, rt, lf, up}
//   in1_n[7:0]            : ~{cocktail, start2, start1, 0, dn2, rt2, lf2, up2}
// Key event -> key state (1 clk) -> arbiter/level/coin register (1 clk).
// Every output bit is the inverse of a single flop, so no glitches.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter bit AUTO_COIN   = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        vblank,
  input  logic        horz,
  input  logic        cocktail,
  output logic [7:0]  in0_n,
  output logic [7:0]  in1_n
);

  localparam int NUM_PLAYERS = 2;
  localparam int NUM_COINS   = 2;
  localparam int CW          = $clog2(COIN_FRAMES + 1);

  // ---------------- key decode ----------------
  logic       tog_q;
  key_state_t keys_q, keys_d;
  logic [8:0] code;
  logic       pressed;

  assign code    = ps2_key[8:0];
  assign pressed = ps2_key[9];

  always_comb begin
    keys_d = keys_q;
    if (ps2_key[10] != tog_q) begin
      case (code)
        KEY_UP:                     keys_d.dir[0][DIR_UP] = pressed;
        KEY_DN:                     keys_d.dir[0][DIR_DN] = pressed;
        KEY_LF:                     keys_d.dir[0][DIR_LF] = pressed;
        KEY_RT:                     keys_d.dir[0][DIR_RT] = pressed;
        KEY_UP2:                    keys_d.dir[1][DIR_UP] = pressed;
        KEY_DN2:                    keys_d.dir[1][DIR_DN] = pressed;
        KEY_LF2:                    keys_d.dir[1][DIR_LF] = pressed;
        KEY_RT2:                    keys_d.dir[1][DIR_RT] = pressed;
        KEY_START1_A, KEY_START1_B: keys_d.start1 = pressed;
        KEY_START2_A, KEY_START2_B: keys_d.start2 = pressed;
        KEY_COIN1:                  keys_d.coin[0] = pressed;
        KEY_COIN2:                  keys_d.coin[1] = pressed;
        KEY_RACK:                   keys_d.rack = pressed;
        KEY_FIRE_A, KEY_FIRE_B:     ;  // recognised, pacman has no fire input
        default:                    ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      tog_q  <= ps2_key[10];
      keys_q <= keys_d;
    end
  end

  // ---------------- joystick merge ----------------
  logic [15:0] joy;
  logic [3:0]  joy_dir;
  logic        start1_lvl, start2_lvl;
  logic        unused_joy;

  assign joy        = joystick_0 | joystick_1;
  assign joy_dir    = {joy[0], joy[1], joy[2], joy[3]};  // R,L,D,U -> DIR_* order
  assign start1_lvl = keys_q.start1 | joy[4];
  assign start2_lvl = keys_q.start2 | joy[5];
  assign unused_joy = ^joy[15:6];

  // ---------------- direction arbitration ----------------
  logic [NUM_PLAYERS-1:0][3:0] raw_dir;
  logic [NUM_PLAYERS-1:0][3:0] arb_dir;

  assign raw_dir[0] = orient(keys_q.dir[0] | joy_dir, horz);
  assign raw_dir[1] = orient(keys_q.dir[1], horz);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_arb
    dir4_arb u_arb (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .raw     (raw_dir[p]),
      .dir     (arb_dir[p])
    );
  end

  // ---------------- level signals ----------------
  logic start1_q, start2_q, rack_q, cocktail_q, vblank_q;
  logic frame_tick;

  assign frame_tick = vblank & ~vblank_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      start1_q   <= 1'b0;
      start2_q   <= 1'b0;
      rack_q     <= 1'b0;
      cocktail_q <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      start1_q   <= start1_lvl;
      start2_q   <= start2_lvl;
      rack_q     <= keys_q.rack;
      cocktail_q <= cocktail;
      vblank_q   <= vblank;
    end
  end

  // ---------------- coin stretchers ----------------
  logic [NUM_COINS-1:0] coin_req;
  logic [NUM_COINS-1:0] coin_on;

  // Free-credit: either start button also drops a coin in slot 1.
  assign coin_req[0] = keys_q.coin[0] | (AUTO_COIN ? (start1_lvl | start2_lvl) : 1'b0);
  assign coin_req[1] = keys_q.coin[1];

  for (genvar c = 0; c < NUM_COINS; c++) begin : g_coin
    coin_state_e    st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req_q;
    logic           on_q, on_d;

    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      case (st_q)
        IDLE: begin
          // a coincident frame tick is deliberately not counted
          if (coin_req[c] && !req_q) begin
            st_d  = ACTIVE;
            cnt_d = '0;
          end
        end
        ACTIVE: begin
          if (frame_tick) begin
            if (cnt_q == CW'(COIN_FRAMES - 1)) begin
              st_d  = WAIT_REL;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WAIT_REL: begin
          // a held request never produces a second pulse
          if (!coin_req[c]) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
      on_d = (st_d == ACTIVE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        req_q <= 1'b0;
        on_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        req_q <= coin_req[c];
        on_q  <= on_d;
      end
    end

    assign coin_on[c] = on_q;
  end

  // ---------------- outputs ----------------
  assign in0_n = ~{1'b0, coin_on[1], coin_on[0], rack_q,
                   arb_dir[0][DIR_DN], arb_dir[0][DIR_RT],
                   arb_dir[0][DIR_LF], arb_dir[0][DIR_UP]};

  assign in1_n = ~{cocktail_q, start2_q, start1_q, 1'b0,
                   arb_dir[1][DIR_DN], arb_dir[1][DIR_RT],
                   arb_dir[1][DIR_LF], arb_dir[1][DIR_UP]};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl (COIN_FRAMES=3, AUTO_COIN=1).
module tb_arcade_input_ctrl;
  import arcade_input_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        vblank, horz, cocktail;
  logic [7:0]  in0_n, in1_n;

  arcade_input_ctrl #(.COIN_FRAMES(3), .AUTO_COIN(1'b1)) dut (
    .clk_sys    (clk),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .vblank     (vblank),
    .horz       (horz),
    .cocktail   (cocktail),
    .in0_n      (in0_n),
    .in1_n      (in1_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] e0;
    logic [7:0] e1;
    string      tag;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, {in0_n, in1_n}, {mon_e.e0, mon_e.e1});
    end
  end

  // Inputs change 2 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int lat, input logic [7:0] e0, input logic [7:0] e1,
                           input string tag);
    sb_t e;
    e.due = cyc + lat;
    e.e0  = e0;
    e.e1  = e1;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      chk("sb_drain_timeout", 16'(sb.size()), 16'd0);
      sb.delete();
    end
    tick(1);
  endtask

  task automatic send_key(input logic pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  // One vblank pulse; the rising edge is seen on the next clock.
  task automatic vbl(input logic [7:0] e0_after, input string tag);
    vblank = 1'b1;
    expect_at(1, e0_after, 8'h7F, tag);
    tick(1);
    vblank = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    vblank     = 1'b0;
    horz       = 1'b0;
    cocktail   = 1'b1;
    #3;
    chk("reset_outputs", {in0_n, in1_n}, 16'hFFFF);
    tick(3);
    chk("reset_held", {in0_n, in1_n}, 16'hFFFF);

    reset_n = 1'b1;
    expect_at(0, 8'hFF, 8'hFF, "rel_same_cycle");
    expect_at(1, 8'hFF, 8'h7F, "rel_cocktail");
    drain();

    // keyboard up, release, unmapped code
    send_key(1'b1, KEY_UP);
    expect_at(1, 8'hFF, 8'h7F, "up_lat1");
    expect_at(2, 8'hFE, 8'h7F, "up_press");
    drain();
    send_key(1'b0, KEY_UP);
    expect_at(2, 8'hFF, 8'h7F, "up_release");
    drain();
    send_key(1'b1, 9'h01A);
    expect_at(2, 8'hFF, 8'h7F, "unmapped");
    expect_at(4, 8'hFF, 8'h7F, "unmapped_late");
    drain();

    // last-pressed-wins
    send_key(1'b1, KEY_UP);
    expect_at(2, 8'hFE, 8'h7F, "arb_up");
    drain();
    send_key(1'b1, KEY_RT);
    expect_at(2, 8'hFB, 8'h7F, "arb_rt_over_up");
    drain();
    send_key(1'b0, KEY_RT);
    expect_at(2, 8'hFE, 8'h7F, "arb_back_to_up");
    drain();
    send_key(1'b1, KEY_DN);
    expect_at(2, 8'hF7, 8'h7F, "arb_dn_over_up");
    drain();
    // two events on consecutive cycles
    send_key(1'b0, KEY_UP);
    tick(1);
    send_key(1'b0, KEY_DN);
    expect_at(1, 8'hF7, 8'h7F, "b2b_dn_held");
    expect_at(2, 8'hFF, 8'h7F, "b2b_all_released");
    drain();

    // simultaneous presses (joystick), then release of winner
    joystick_0 = 16'h000C;
    expect_at(1, 8'hFE, 8'h7F, "simul_up_dn");
    drain();
    joystick_0 = 16'h0004;
    expect_at(1, 8'hF7, 8'h7F, "fallback_dn");
    drain();
    joystick_0 = 16'h0000;
    expect_at(1, 8'hFF, 8'h7F, "joy_release");
    drain();

    // orientation
    horz = 1'b1;
    joystick_0 = 16'h0002;
    expect_at(1, 8'hFE, 8'h7F, "horz_left_to_up");
    drain();
    horz = 1'b0;
    expect_at(1, 8'hFD, 8'h7F, "vert_left");
    drain();
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0001;
    expect_at(1, 8'hFB, 8'h7F, "joy1_right");
    drain();
    joystick_1 = 16'h0000;
    expect_at(1, 8'hFF, 8'h7F, "joy1_release");
    drain();

    // player 2 keys, rack
    send_key(1'b1, KEY_LF2);
    expect_at(2, 8'hFF, 8'h7D, "p2_left");
    drain();
    horz = 1'b1;
    expect_at(1, 8'hFF, 8'h7E, "p2_horz_up");
    drain();
    horz = 1'b0;
    expect_at(1, 8'hFF, 8'h7D, "p2_vert_left");
    drain();
    send_key(1'b0, KEY_LF2);
    expect_at(2, 8'hFF, 8'h7F, "p2_release");
    drain();
    send_key(1'b1, KEY_RACK);
    expect_at(2, 8'hEF, 8'h7F, "rack");
    drain();
    send_key(1'b0, KEY_RACK);
    expect_at(2, 8'hFF, 8'h7F, "rack_release");
    drain();

    // coin1 held across 5 frames
    send_key(1'b1, KEY_COIN1);
    expect_at(1, 8'hFF, 8'h7F, "coin_lat1");
    expect_at(2, 8'hDF, 8'h7F, "coin_on");
    drain();
    for (int i = 0; i < 5; i++) vbl((i < 2) ? 8'hDF : 8'hFF, "coin_frames");
    drain();
    send_key(1'b0, KEY_COIN1);
    expect_at(2, 8'hFF, 8'h7F, "coin_release");
    drain();
    // re-press: new pulse; a release+re-press mid-pulse does not restart it
    send_key(1'b1, KEY_COIN1);
    expect_at(2, 8'hDF, 8'h7F, "coin_repress");
    drain();
    vbl(8'hDF, "coin2nd_f1");
    send_key(1'b0, KEY_COIN1);
    expect_at(2, 8'hDF, 8'h7F, "coin_midrel");
    drain();
    send_key(1'b1, KEY_COIN1);
    expect_at(2, 8'hDF, 8'h7F, "coin_midpress");
    drain();
    vbl(8'hDF, "coin2nd_f2");
    vbl(8'hFF, "coin2nd_f3");
    drain();
    send_key(1'b0, KEY_COIN1);
    expect_at(2, 8'hFF, 8'h7F, "coin_release2");
    drain();

    // coin abort by reset
    send_key(1'b1, KEY_COIN1);
    expect_at(2, 8'hDF, 8'h7F, "abort_on");
    drain();
    vbl(8'hDF, "abort_f1");
    drain();
    reset_n = 1'b0;
    #1;
    chk("abort_async", {in0_n, in1_n}, 16'hFFFF);
    ps2_key = {1'b0, ps2_key[9:0]};
    tick(2);
    reset_n = 1'b1;
    expect_at(0, 8'hFF, 8'hFF, "abort_rel0");
    for (int i = 1; i <= 4; i++) expect_at(i, 8'hFF, 8'h7F, "abort_idle");
    drain();
    send_key(1'b1, KEY_COIN1);
    expect_at(2, 8'hDF, 8'h7F, "abort_new_pulse");
    drain();
    for (int i = 0; i < 3; i++) vbl((i < 2) ? 8'hDF : 8'hFF, "abort_frames");
    drain();
    send_key(1'b0, KEY_COIN1);
    expect_at(2, 8'hFF, 8'h7F, "abort_release");
    drain();

    // coin2
    send_key(1'b1, KEY_COIN2);
    expect_at(2, 8'hBF, 8'h7F, "coin2_on");
    drain();
    for (int i = 0; i < 3; i++) begin
      vblank = 1'b1;
      expect_at(1, (i < 2) ? 8'hBF : 8'hFF, 8'h7F, "coin2_frames");
      tick(1);
      vblank = 1'b0;
      tick(1);
    end
    drain();
    send_key(1'b0, KEY_COIN2);
    expect_at(2, 8'hFF, 8'h7F, "coin2_release");
    drain();

    // start1 with free credit
    joystick_0 = 16'h0010;
    expect_at(1, 8'hDF, 8'h5F, "start1_autocoin");
    drain();
    for (int i = 0; i < 3; i++) begin
      vblank = 1'b1;
      expect_at(1, (i < 2) ? 8'hDF : 8'hFF, 8'h5F, "start1_frames");
      tick(1);
      vblank = 1'b0;
      tick(1);
    end
    drain();
    joystick_0 = 16'h0000;
    expect_at(1, 8'hFF, 8'h7F, "start1_release");
    drain();
    send_key(1'b1, KEY_START2_B);
    expect_at(2, 8'hDF, 8'h3F, "start2_key");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", 1);
    $fatal(1);
  end

endmodule
